// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  // Dump channel FSM states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_t;

  // Default geometry of the bank.
  localparam int DEF_NUM_EVENTS = 11;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_SATURATE   = 0;

  // Event channel assignment used by the mp4 core.
  localparam int EV_I_HIT      = 0;
  localparam int EV_I_MISS     = 1;
  localparam int EV_D_HIT      = 2;
  localparam int EV_D_MISS     = 3;
  localparam int EV_MISPREDICT = 4;
  localparam int EV_STALL_ALL  = 5;
  localparam int EV_STALL_FE   = 6;
  localparam int EV_STALL_DE   = 7;
  localparam int EV_STALL_EXE  = 8;
  localparam int EV_STALL_MEM  = 9;
  localparam int EV_PF_USED    = 10;

  // Channel index width; a single-channel bank still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Snapshot dump channel: valid/ready stream of {idx, count, ovf, last}.
interface perf_counter_bank_if #(
  parameter int IDX_W     = 4,
  parameter int CNT_WIDTH = 32
) ();
  logic                 busy_o;
  logic                 dump_valid_o;
  logic                 dump_ready_i;
  logic [IDX_W-1:0]     dump_idx_o;
  logic [CNT_WIDTH-1:0] dump_data_o;
  logic                 dump_ovf_o;
  logic                 dump_last_o;

  modport master (
    output busy_o, dump_valid_o, dump_idx_o, dump_data_o, dump_ovf_o, dump_last_o,
    input  dump_ready_i
  );

  modport slave (
    input  busy_o, dump_valid_o, dump_idx_o, dump_data_o, dump_ovf_o, dump_last_o,
    output dump_ready_i
  );
endinterface

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear, wrap/saturate overflow and
// a sticky overflow flag.
module perf_counter #(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 ovf_nxt;

  // Next count: clear beats increment; the all-ones case wraps or holds.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    if (clear) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (enable && inc) begin
      if (count == {CNT_WIDTH{1'b1}}) begin
        ovf_nxt = 1'b1;
        if (SATURATE != 0) begin
          count_nxt = count;
        end else begin
          count_nxt = '0;
        end
      end else begin
        count_nxt = count + CNT_WIDTH'(1);
      end
    end else begin
      count_nxt = count;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a live read port and an atomic snapshot that
// is streamed out over the dump channel while live counting continues.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = DEF_NUM_EVENTS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int SATURATE   = DEF_SATURATE,
  parameter int IDX_W      = idx_width(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  clear_i,
  input  logic [IDX_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  rd_ovf_o,
  input  logic                  snap_req_i,
  perf_counter_bank_if.master   dump
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS - 1);

  logic [CNT_WIDTH-1:0]  live_cnt [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] live_ovf;
  logic [CNT_WIDTH-1:0]  shadow_r [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] shadow_ovf_r;

  dump_state_t      state_r, state_nxt;
  logic [IDX_W-1:0] idx_r, idx_nxt;
  logic             snap_load;

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_ch
    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_i),
      .enable (enable_i),
      .inc    (event_i[g]),
      .count  (live_cnt[g]),
      .ovf    (live_ovf[g])
    );
  end

  // Live read mux; unused select codes read as zero.
  always_comb begin
    rd_data_o = '0;
    rd_ovf_o  = 1'b0;
    if (rd_sel_i <= LAST_IDX) begin
      rd_data_o = live_cnt[rd_sel_i];
      rd_ovf_o  = live_ovf[rd_sel_i];
    end else begin
      rd_data_o = '0;
      rd_ovf_o  = 1'b0;
    end
  end

  // Dump FSM next state: accept a snapshot in IDLE, walk the channels in DUMP.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    snap_load = 1'b0;
    case (state_r)
      IDLE: begin
        if (snap_req_i) begin
          snap_load = 1'b1;
          idx_nxt   = '0;
          state_nxt = DUMP;
        end else begin
          state_nxt = IDLE;
        end
      end
      DUMP: begin
        if (dump.dump_ready_i) begin
          if (idx_r == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx_r + IDX_W'(1);
          end
        end else begin
          idx_nxt = idx_r;
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and beat index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt;
      idx_r   <= idx_nxt;
    end
  end

  // Shadow copy takes the pre-edge live values, so a same-cycle clear or
  // event is not part of the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        shadow_r[k] <= '0;
      end
      shadow_ovf_r <= '0;
    end else if (snap_load) begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        shadow_r[k] <= live_cnt[k];
      end
      shadow_ovf_r <= live_ovf;
    end
  end

  // Dump channel outputs; the payload is driven to zero outside a dump.
  always_comb begin
    dump.busy_o       = 1'b0;
    dump.dump_valid_o = 1'b0;
    dump.dump_idx_o   = '0;
    dump.dump_data_o  = '0;
    dump.dump_ovf_o   = 1'b0;
    dump.dump_last_o  = 1'b0;
    if (state_r == DUMP) begin
      dump.busy_o       = 1'b1;
      dump.dump_valid_o = 1'b1;
      dump.dump_idx_o   = idx_r;
      dump.dump_data_o  = shadow_r[idx_r];
      dump.dump_ovf_o   = shadow_ovf_r[idx_r];
      dump.dump_last_o  = (idx_r == LAST_IDX);
    end else begin
      dump.busy_o       = 1'b0;
      dump.dump_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: a 32-bit wrap bank, a 4-bit wrap bank and a 4-bit
// saturate bank driven by the same stimulus, compared against an
// events-since-clear reference model plus directed sequences.
module tb_perf_counter_bank;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] ev;
  logic        clr;
  logic [3:0]  sel;
  logic        snap;
  logic        ready;

  logic [31:0] rd_m;
  logic [3:0]  rd_w, rd_s;
  logic        ro_m, ro_w, ro_s;

  always #5 clk = ~clk;

  perf_counter_bank_if #(.IDX_W(4), .CNT_WIDTH(32)) if_m ();
  perf_counter_bank_if #(.IDX_W(4), .CNT_WIDTH(4))  if_w ();
  perf_counter_bank_if #(.IDX_W(4), .CNT_WIDTH(4))  if_s ();
  assign if_m.dump_ready_i = ready;
  assign if_w.dump_ready_i = ready;
  assign if_s.dump_ready_i = ready;

  perf_counter_bank #(.NUM_EVENTS(11), .CNT_WIDTH(32), .SATURATE(0)) u_main (
    .clk(clk), .rst(rst), .enable_i(en), .event_i(ev), .clear_i(clr), .rd_sel_i(sel),
    .rd_data_o(rd_m), .rd_ovf_o(ro_m), .snap_req_i(snap), .dump(if_m));
  perf_counter_bank #(.NUM_EVENTS(11), .CNT_WIDTH(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .enable_i(en), .event_i(ev), .clear_i(clr), .rd_sel_i(sel),
    .rd_data_o(rd_w), .rd_ovf_o(ro_w), .snap_req_i(snap), .dump(if_w));
  perf_counter_bank #(.NUM_EVENTS(11), .CNT_WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .enable_i(en), .event_i(ev), .clear_i(clr), .rd_sel_i(sel),
    .rd_data_o(rd_s), .rd_ovf_o(ro_s), .snap_req_i(snap), .dump(if_s));

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, the number of counted events since the last
  // clear/reset; each bank's count and flag are derived from that number.
  longint unsigned n  [11];
  longint unsigned sh [11];
  bit              m_busy;
  int              m_idx;

  function automatic logic [31:0] exp_cnt(input int d, input longint unsigned x);
    if (d == 0) return x[31:0];
    else if (d == 1) return 32'(x % 64'd16);
    else return (x >= 64'd15) ? 32'd15 : x[31:0];
  endfunction

  function automatic logic exp_ovf(input int d, input longint unsigned x);
    if (d == 0) return x >= 64'h1_0000_0000;
    else return x >= 64'd16;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 11; k++) begin
      n[k]  = 0;
      sh[k] = 0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    if (m_busy) begin
      if (ready) begin
        if (m_idx == 10) m_busy = 1'b0;
        else m_idx++;
      end
    end else if (snap) begin
      for (int k = 0; k < 11; k++) sh[k] = n[k];
      m_busy = 1'b1;
      m_idx  = 0;
    end
    for (int k = 0; k < 11; k++) begin
      if (clr) n[k] = 0;
      else if (en && ev[k]) n[k]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_dut(input string nm, input int d, input logic [31:0] rd, input logic ro,
                           input logic v, input logic b, input logic [3:0] ix,
                           input logic [31:0] dd, input logic o, input logic l);
    chk({nm, " rd_data"}, 64'(rd), (sel < 4'd11) ? 64'(exp_cnt(d, n[sel])) : 64'd0);
    chk({nm, " rd_ovf"}, 64'(ro), (sel < 4'd11) ? 64'(exp_ovf(d, n[sel])) : 64'd0);
    chk({nm, " valid"}, 64'(v), 64'(m_busy));
    chk({nm, " busy"}, 64'(b), 64'(m_busy));
    if (m_busy) begin
      chk({nm, " dump_idx"}, 64'(ix), 64'(m_idx));
      chk({nm, " dump_data"}, 64'(dd), 64'(exp_cnt(d, sh[m_idx])));
      chk({nm, " dump_ovf"}, 64'(o), 64'(exp_ovf(d, sh[m_idx])));
      chk({nm, " dump_last"}, 64'(l), 64'(m_idx == 10));
    end else begin
      chk({nm, " idle data"}, 64'(dd), 64'd0);
      chk({nm, " idle last"}, 64'(l), 64'd0);
    end
  endtask

  task automatic check_all();
    check_dut("main", 0, rd_m, ro_m, if_m.dump_valid_o, if_m.busy_o, if_m.dump_idx_o,
              if_m.dump_data_o, if_m.dump_ovf_o, if_m.dump_last_o);
    check_dut("wrap", 1, {28'd0, rd_w}, ro_w, if_w.dump_valid_o, if_w.busy_o, if_w.dump_idx_o,
              {28'd0, if_w.dump_data_o}, if_w.dump_ovf_o, if_w.dump_last_o);
    check_dut("sat", 2, {28'd0, rd_s}, ro_s, if_s.dump_valid_o, if_s.busy_o, if_s.dump_idx_o,
              {28'd0, if_s.dump_data_o}, if_s.dump_ovf_o, if_s.dump_last_o);
  endtask

  typedef struct {
    logic        en;
    logic [10:0] ev;
    logic        clr;
    logic [3:0]  sel;
    logic [31:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vec [21];

  function automatic vec_t mk(input logic e, input logic [10:0] v, input logic c,
                              input logic [3:0] s, input logic [31:0] d, input logic o);
    vec_t r;
    r.en = e; r.ev = v; r.clr = c; r.sel = s; r.exp_d = d; r.exp_o = o;
    return r;
  endfunction

  initial begin : main
    int beats;
    int hold_ok;
    logic [3:0]  held_idx;
    logic [31:0] held_data;
    logic [31:0] exp_d;

    // Live-count vectors starting from reset (main bank, value after the edge).
    for (int i = 0; i < 5; i++) vec[i] = mk(1'b1, 11'h008, 1'b0, 4'd3, 32'(i + 1), 1'b0);
    vec[5]  = mk(1'b1, 11'h000, 1'b0, 4'd3, 32'd5, 1'b0);
    vec[6]  = mk(1'b1, 11'h000, 1'b0, 4'd0, 32'd0, 1'b0);
    vec[7]  = mk(1'b1, 11'h000, 1'b0, 4'd5, 32'd0, 1'b0);
    vec[8]  = mk(1'b1, 11'h000, 1'b0, 4'd11, 32'd0, 1'b0);
    vec[9]  = mk(1'b1, 11'h000, 1'b0, 4'd15, 32'd0, 1'b0);
    vec[10] = mk(1'b0, 11'h7FF, 1'b0, 4'd3, 32'd5, 1'b0);
    vec[11] = mk(1'b0, 11'h7FF, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) vec[12 + i] = mk(1'b1, 11'h001, 1'b0, 4'd0, 32'(i + 1), 1'b0);
    vec[19] = mk(1'b1, 11'h001, 1'b1, 4'd0, 32'd0, 1'b0);
    vec[20] = mk(1'b1, 11'h000, 1'b0, 4'd3, 32'd0, 1'b0);

    rst = 1'b1; en = 1'b0; ev = '0; clr = 1'b0; sel = '0; snap = 1'b0; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    chk("reset valid", 64'(if_m.dump_valid_o), 64'd0);
    chk("reset busy", 64'(if_m.busy_o), 64'd0);
    chk("reset last", 64'(if_m.dump_last_o), 64'd0);
    chk("reset idx", 64'(if_m.dump_idx_o), 64'd0);
    chk("reset data", 64'(if_m.dump_data_o), 64'd0);
    chk("reset ovf", 64'(if_m.dump_ovf_o), 64'd0);
    chk("reset rd", 64'(rd_m), 64'd0);

    // Table-driven live counting.
    for (int i = 0; i < 21; i++) begin
      en = vec[i].en; ev = vec[i].ev; clr = vec[i].clr; sel = vec[i].sel;
      step();
      chk($sformatf("vec%0d rd_data", i), 64'(rd_m), 64'(vec[i].exp_d));
      chk($sformatf("vec%0d rd_ovf", i), 64'(ro_m), 64'(vec[i].exp_o));
      check_all();
    end

    // 17 events on ch0: 4-bit wrap reads 1, saturate reads 15, both flag overflow.
    en = 1'b1; ev = 11'h001; clr = 1'b0; sel = 4'd0;
    repeat (17) begin
      step();
      check_all();
    end
    chk("wrap17 count", 64'(rd_w), 64'd1);
    chk("wrap17 ovf", 64'(ro_w), 64'd1);
    chk("sat17 count", 64'(rd_s), 64'd15);
    chk("sat17 ovf", 64'(ro_s), 64'd1);
    chk("main17 count", 64'(rd_m), 64'd17);
    ev = 11'h000; clr = 1'b1;
    step();
    chk("clear ovf", 64'(ro_w), 64'd0);
    clr = 1'b0;

    // Load counts 1..11: channel k is pulsed in cycles 0..k.
    for (int j = 0; j < 11; j++) begin
      ev = 11'h7FF << j;
      step();
      check_all();
    end

    // Snapshot with constant ready while ch0 keeps counting.
    ev = 11'h001; snap = 1'b1; ready = 1'b1;
    step();
    snap = 1'b0;
    for (int b = 0; b < 11; b++) begin
      chk("dump valid", 64'(if_m.dump_valid_o), 64'd1);
      chk("dump idx", 64'(if_m.dump_idx_o), 64'(b));
      chk("dump data", 64'(if_m.dump_data_o), 64'(b + 1));
      chk("dump last", 64'(if_m.dump_last_o), 64'(b == 10));
      step();
      check_all();
    end
    chk("dump end valid", 64'(if_m.dump_valid_o), 64'd0);
    sel = 4'd0;
    #1 chk("ch0 advanced", 64'(rd_m), 64'd13);

    // Stalled dump with a second request mid-dump that must be ignored.
    ev = 11'h000; snap = 1'b1; ready = 1'b0;
    step();
    snap = 1'b0;
    beats = 0; hold_ok = 0; held_idx = '0; held_data = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      ready = cyc[0];
      snap  = (cyc == 4);
      if (if_m.dump_valid_o) begin
        if (hold_ok != 0) begin
          chk("stall idx held", 64'(if_m.dump_idx_o), 64'(held_idx));
          chk("stall data held", 64'(if_m.dump_data_o), 64'(held_data));
        end
        if (ready) begin
          exp_d = (beats == 0) ? 32'd13 : 32'(beats + 1);
          chk("stall beat idx", 64'(if_m.dump_idx_o), 64'(beats));
          chk("stall beat data", 64'(if_m.dump_data_o), 64'(exp_d));
          beats++;
          hold_ok = 0;
        end else begin
          held_idx  = if_m.dump_idx_o;
          held_data = if_m.dump_data_o;
          hold_ok   = 1;
        end
      end
      step();
      check_all();
      if (beats == 11) break;
    end
    snap = 1'b0; ready = 1'b0;
    chk("stall beat count", 64'(beats), 64'd11);
    chk("second snap ignored", 64'(if_m.dump_valid_o), 64'd0);

    // Reset during beat 4 aborts the dump and zeroes everything.
    snap = 1'b1; ready = 1'b1;
    step();
    snap = 1'b0;
    repeat (4) begin
      step();
      check_all();
    end
    chk("pre-rst idx", 64'(if_m.dump_idx_o), 64'd4);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst valid", 64'(if_m.dump_valid_o), 64'd0);
    chk("rst busy", 64'(if_m.busy_o), 64'd0);
    chk("rst rd", 64'(rd_m), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snap = 1'b1;
    step();
    snap = 1'b0;
    for (int b = 0; b < 11; b++) begin
      chk("zero dump data", 64'(if_m.dump_data_o), 64'd0);
      chk("zero dump idx", 64'(if_m.dump_idx_o), 64'(b));
      step();
      check_all();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(7) != 0);
      ev    = 11'($urandom);
      clr   = ($urandom_range(63) == 0);
      sel   = 4'($urandom);
      snap  = ($urandom_range(15) == 0);
      ready = ($urandom_range(3) != 0);
      step();
      check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
